// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if -- control bus between the instruction sequencer and the datapath.
//
// Signals:
//   mach_code  [8:0]  instruction word from fetch, held while pc_en=0
//   Aluop/Ra/Rb/Wd    ALU opcode, operand A/B and destination register selects
//   Jptr [7:0]        jump target (zero-extended mach_code[5:0])
//   LdcVal [4:0]      load-constant immediate (mach_code[5:1])
//   WenR/WenD/RenD    register write, data-memory write, data-memory read
//   MemToReg/Jen/Ldcen  writeback mux select, jump enable, load-constant enable
//   Done              program halted
//   stall             current instruction has not retired this cycle
//   pc_en             instruction retires at the coming edge; fetch advances
//   retire_cnt [15:0] retired-instruction counter (only with CTRL_PERF_CNT_EN)
//
// Modports: master = sequencer side (drives control), slave = fetch/datapath side.
interface ctrl_seq_if;
  logic [8:0] mach_code;
  logic [2:0] Aluop;
  logic [2:0] Ra;
  logic [2:0] Rb;
  logic [2:0] Wd;
  logic [7:0] Jptr;
  logic [4:0] LdcVal;
  logic       WenR;
  logic       WenD;
  logic       RenD;
  logic       MemToReg;
  logic       Jen;
  logic       Ldcen;
  logic       Done;
  logic       stall;
  logic       pc_en;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] retire_cnt;

  modport master (
    input  mach_code,
    output Aluop, Ra, Rb, Wd, Jptr, LdcVal,
    output WenR, WenD, RenD, MemToReg, Jen, Ldcen,
    output Done, stall, pc_en, retire_cnt
  );

  modport slave (
    output mach_code,
    input  Aluop, Ra, Rb, Wd, Jptr, LdcVal,
    input  WenR, WenD, RenD, MemToReg, Jen, Ldcen,
    input  Done, stall, pc_en, retire_cnt
  );
`else
  modport master (
    input  mach_code,
    output Aluop, Ra, Rb, Wd, Jptr, LdcVal,
    output WenR, WenD, RenD, MemToReg, Jen, Ldcen,
    output Done, stall, pc_en
  );

  modport slave (
    output mach_code,
    input  Aluop, Ra, Rb, Wd, Jptr, LdcVal,
    input  WenR, WenD, RenD, MemToReg, Jen, Ldcen,
    input  Done, stall, pc_en
  );
`endif
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq -- instruction decoder and multi-cycle sequencer for a small
// 9-bit-instruction datapath.
//
// Decodes the current mach_code into datapath control every cycle and runs a
// RUN / MEM_WAIT / HALT FSM that stretches loads and stores to MEM_LAT+1
// cycles, halts on 011111111, and tells fetch when to advance (pc_en).
//
// Parameters:
//   MEM_LAT      extra wait cycles per load/store (0..7)
//   FLAG_REG     destination register of compare instructions
//   LD_ADDR_REG  register holding the load address (also load-constant dest)
//   ST_ADDR_REG  register holding the store address
//
// Ports:
//   Clk    clock, all state on the rising edge
//   Reset  synchronous, active-high reset
//   bus    ctrl_seq_if.master -- mach_code in, all control outputs out
//
// Optional feature: define CTRL_PERF_CNT_EN to build the saturating 16-bit
// retire_cnt counter; without it the counter and port do not exist.
module ctrl_seq #(
  parameter int unsigned MEM_LAT     = 2,
  parameter logic [2:0]  FLAG_REG    = 3'b101,
  parameter logic [2:0]  LD_ADDR_REG = 3'b110,
  parameter logic [2:0]  ST_ADDR_REG = 3'b111
) (
  input  logic        Clk,
  input  logic        Reset,
  ctrl_seq_if.master  bus
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [2:0] wcnt, wcnt_n;

  logic [8:0] mc;
  assign mc = bus.mach_code;

  // ---------------------------------------------------------------------------
  // Instruction classes. Halt is checked before the others so that the
  // remaining classes can be tested independently.
  // ---------------------------------------------------------------------------
  logic is_halt, is_cmp, is_br, is_ld, is_ldc, is_st, is_mov, is_mem;

  always_comb begin
    is_halt = (mc == 9'b011111111);
    is_cmp  = !is_halt && (mc[8:5] == 4'b0110);
    is_br   = (mc[8:6] == 3'b100);
    is_ld   = (mc[8:6] == 3'b110) && !mc[0];
    is_ldc  = (mc[8:6] == 3'b110) &&  mc[0];
    is_st   = (mc[8:6] == 3'b101);
    is_mov  = (mc[8:6] == 3'b111);
    is_mem  = is_ld || is_st;
  end

  // ---------------------------------------------------------------------------
  // Pure decode: what each instruction asks of the datapath, before the FSM
  // decides whether this cycle actually commits the write.
  // ---------------------------------------------------------------------------
  logic [2:0] d_aluop, d_ra, d_rb, d_wd;
  logic       d_wenr, d_wend, d_rend, d_m2r, d_jen, d_ldcen;

  always_comb begin
    d_aluop = mc[7:5];
    d_ra    = {1'b0, mc[4:3]};
    d_rb    = mc[2:0];
    d_wd    = mc[2:0];
    d_wenr  = 1'b1;
    d_wend  = 1'b0;
    d_rend  = 1'b0;
    d_m2r   = 1'b1;
    d_jen   = 1'b0;
    d_ldcen = 1'b0;

    if (is_halt) begin
      d_wenr = 1'b0;
    end else if (is_cmp) begin
      d_wd = FLAG_REG;
    end else if (is_br) begin
      d_wenr = 1'b0;
      d_jen  = 1'b1;
    end else if (is_ldc) begin
      d_ldcen = 1'b1;
      d_wd    = LD_ADDR_REG;
    end else if (is_ld) begin
      d_rend = 1'b1;
      d_m2r  = 1'b0;
      d_ra   = LD_ADDR_REG;
      d_wd   = mc[5:3];
    end else if (is_st) begin
      d_wenr = 1'b0;
      d_wend = 1'b1;
      d_ra   = ST_ADDR_REG;
      d_rb   = mc[5:3];
    end else if (is_mov) begin
      d_aluop = 3'b111;
      d_ra    = mc[5:3];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= RUN;
      wcnt  <= 3'd0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. wcnt counts the remaining wait cycles; the cycle that
  // sees wcnt==1 is the one that commits the memory access.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    case (state)
      RUN: begin
        if (is_halt) begin
          state_n = HALT;
        end else if (is_mem && (LAT != 3'd0)) begin
          state_n = MEM_WAIT;
          wcnt_n  = LAT;
        end
      end
      MEM_WAIT: begin
        wcnt_n = wcnt - 3'd1;
        if (wcnt == 3'd1) state_n = RUN;
      end
      HALT:    state_n = HALT;
      default: state_n = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. While Reset is high the outputs show the RUN-state decode
  // with every commit suppressed, so an access interrupted by reset never
  // issues its write.
  // ---------------------------------------------------------------------------
  state_t st_eff;
  logic   o_wenr, o_wend, o_rend, o_jen, o_ldcen, o_done, o_stall, o_pc_en;

  assign st_eff = Reset ? RUN : state;

  always_comb begin
    o_wenr  = d_wenr;
    o_wend  = d_wend;
    o_rend  = d_rend;
    o_jen   = d_jen;
    o_ldcen = d_ldcen;
    o_done  = 1'b0;
    o_stall = 1'b0;
    o_pc_en = 1'b0;

    case (st_eff)
      RUN: begin
        if (is_halt) begin
          o_done = 1'b1;
          o_wenr = 1'b0;
        end else if (is_mem && (LAT != 3'd0)) begin
          // first cycle of a stretched access: address out, no commit yet
          o_stall = 1'b1;
          o_wenr  = 1'b0;
          o_wend  = 1'b0;
        end else begin
          o_pc_en = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (wcnt == 3'd1) begin
          o_pc_en = 1'b1;
        end else begin
          o_stall = 1'b1;
          o_wenr  = 1'b0;
          o_wend  = 1'b0;
        end
      end
      HALT: begin
        o_done  = 1'b1;
        o_wenr  = 1'b0;
        o_wend  = 1'b0;
        o_rend  = 1'b0;
        o_jen   = 1'b0;
        o_ldcen = 1'b0;
      end
      default: begin
        o_wenr = 1'b0;
        o_wend = 1'b0;
      end
    endcase

    if (Reset) begin
      o_pc_en = 1'b0;
      o_wenr  = 1'b0;
      o_wend  = 1'b0;
      o_done  = 1'b0;
    end
  end

  assign bus.Aluop    = d_aluop;
  assign bus.Ra       = d_ra;
  assign bus.Rb       = d_rb;
  assign bus.Wd       = d_wd;
  assign bus.Jptr     = {2'b00, mc[5:0]};
  assign bus.LdcVal   = mc[5:1];
  assign bus.MemToReg = d_m2r;
  assign bus.WenR     = o_wenr;
  assign bus.WenD     = o_wend;
  assign bus.RenD     = o_rend;
  assign bus.Jen      = o_jen;
  assign bus.Ldcen    = o_ldcen;
  assign bus.Done     = o_done;
  assign bus.stall    = o_stall;
  assign bus.pc_en    = o_pc_en;

`ifdef CTRL_PERF_CNT_EN
  // Saturating retire counter: counts edges at which an instruction retires.
  logic [15:0] rcnt;

  always_ff @(posedge Clk) begin
    if (Reset)                          rcnt <= 16'd0;
    else if (o_pc_en && rcnt != 16'hFFFF) rcnt <= rcnt + 16'd1;
  end

  assign bus.retire_cnt = rcnt;
`endif

  // A retiring instruction writes at most one destination, and a cycle that
  // retires is never also a stall cycle.
  a_one_write: assert property (@(posedge Clk) !(o_wenr && o_wend));
  a_pc_stall:  assert property (@(posedge Clk) !(o_pc_en && o_stall));
  a_done_pc:   assert property (@(posedge Clk) !(o_done && o_pc_en));

endmodule
